jpeg_transform_block: RTL and testbench

JPEG_TRANSFORM_BLOCK -- requirements
Module: jpeg_transform_block

---
 rtl/jpeg_transform_block.sv | 91 +++++++++
 tb/tb_jpeg_transform_block.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_transform_block.sv
// Dequantize one 8x8 JPEG block per cycle: 64 parallel signed*unsigned lanes
// feeding a fixed zigzag-to-raster reorder, registered once at the output.

module jpeg_dq_lane #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 32
) (
    input  logic [WIDTH_IN-1:0]  coef,
    input  logic [WIDTH_IN-1:0]  quant,
    output logic [WIDTH_OUT-1:0] prod
);
    localparam int PW = 2*WIDTH_IN + 1;

    logic signed [PW-1:0] coef_x;
    logic signed [PW-1:0] quant_x;
    logic signed [PW-1:0] full;

    // Both operands widened to the exact product width so the multiply is lossless
    assign coef_x  = {{(WIDTH_IN+1){coef[WIDTH_IN-1]}}, coef};
    assign quant_x = {{(WIDTH_IN+1){1'b0}}, quant};
    assign full    = coef_x * quant_x;

    generate
        if (WIDTH_OUT > PW) begin : g_ext
            assign prod = {{(WIDTH_OUT-PW){full[PW-1]}}, full};
        end else if (WIDTH_OUT == PW) begin : g_eq
            assign prod = full;
        end else begin : g_trunc
            assign prod = full[WIDTH_OUT-1:0];
        end
    endgenerate
endmodule

module jpeg_transform_block #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [WIDTH_IN*64-1:0]  zz_in_flat,
    input  logic [WIDTH_IN*64-1:0]  quant_flat,
    output logic                    out_valid,
    output logic [WIDTH_OUT*64-1:0] dct_out_flat
);
    localparam int STAGES = 1;

    // Zigzag index held at each raster position r*8+c
    localparam int ZZ_IDX [0:63] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

    logic [63:0][WIDTH_OUT-1:0] prod;
    logic [63:0][WIDTH_OUT-1:0] data_q;
    logic [STAGES:0]            vld_pipe;

    generate
        for (genvar p = 0; p < 64; p++) begin : g_lane
            jpeg_dq_lane #(
                .WIDTH_IN  (WIDTH_IN),
                .WIDTH_OUT (WIDTH_OUT)
            ) u_lane (
                .coef  (zz_in_flat[ZZ_IDX[p]*WIDTH_IN +: WIDTH_IN]),
                .quant (quant_flat[ZZ_IDX[p]*WIDTH_IN +: WIDTH_IN]),
                .prod  (prod[p])
            );
        end
    endgenerate

    assign vld_pipe[0] = in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
            data_q             <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (in_valid) data_q <= prod;
        end
    end

    assign out_valid    = vld_pipe[STAGES];
    assign dct_out_flat = data_q;
endmodule

// File: tb/tb_jpeg_transform_block.sv
// Directed bench for jpeg_transform_block: zigzag reorder, dequant math,
// sign range, hold, reset and back-to-back streaming.

module tb_jpeg_transform_block;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [1023:0] zz_in_flat;
    logic [1023:0] quant_flat;
    logic          out_valid;
    logic [2047:0] dct_out_flat;

    int checks = 0;
    int errors = 0;

    // Raster position -> zigzag index, straight from the JPEG table
    int ZZ_TAB [64] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

    jpeg_transform_block #(.WIDTH_IN(16), .WIDTH_OUT(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .zz_in_flat   (zz_in_flat),
        .quant_flat   (quant_flat),
        .out_valid    (out_valid),
        .dct_out_flat (dct_out_flat)
    );

    always #5 clk = ~clk;

    function automatic int lane(input int p);
        logic signed [31:0] v;
        v = dct_out_flat[p*32 +: 32];
        return int'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            zz_in_flat[k*16 +: 16] = 16'd7;
            quant_flat[k*16 +: 16] = 16'd3;
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        checks++;
        if (dct_out_flat !== '0) begin
            errors++;
            $display("FAIL reset_data got nonzero want 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_zigzag();
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            zz_in_flat[k*16 +: 16] = 16'(k);
            quant_flat[k*16 +: 16] = 16'd1;
        end
        in_valid = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL zigzag_valid got %b want 1", out_valid);
        end
        for (int p = 0; p < 64; p++) begin
            checks++;
            if (lane(p) !== ZZ_TAB[p]) begin
                errors++;
                $display("FAIL zigzag_pos%0d got %0d want %0d", p, lane(p), ZZ_TAB[p]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zigzag_pulse got %b want 0", out_valid);
        end
    endtask

    task automatic test_multiply();
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            zz_in_flat[k*16 +: 16] = 16'd10;
            quant_flat[k*16 +: 16] = 16'd5;
        end
        in_valid = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mult_valid got %b want 1", out_valid);
        end
        for (int p = 0; p < 64; p++) begin
            checks++;
            if (lane(p) !== 50) begin
                errors++;
                $display("FAIL mult_pos%0d got %0d want 50", p, lane(p));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_sparse();
        int exp;
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            zz_in_flat[k*16 +: 16] = 16'd0;
            quant_flat[k*16 +: 16] = 16'd1;
        end
        zz_in_flat[0*16 +: 16] = 16'd10; quant_flat[0*16 +: 16] = 16'd2;
        zz_in_flat[1*16 +: 16] = 16'd5;  quant_flat[1*16 +: 16] = 16'd3;
        zz_in_flat[2*16 +: 16] = 16'd2;  quant_flat[2*16 +: 16] = 16'd4;
        in_valid = 1'b1;
        step();
        for (int p = 0; p < 64; p++) begin
            exp = (p == 0) ? 20 : (p == 1) ? 15 : (p == 8) ? 8 : 0;
            checks++;
            if (lane(p) !== exp) begin
                errors++;
                $display("FAIL sparse_pos%0d got %0d want %0d", p, lane(p), exp);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_sign();
        int exp;
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            zz_in_flat[k*16 +: 16] = 16'd0;
            quant_flat[k*16 +: 16] = 16'd1;
        end
        zz_in_flat[5*16 +: 16]  = 16'hFFFD; quant_flat[5*16 +: 16]  = 16'd7;
        zz_in_flat[63*16 +: 16] = 16'h8000; quant_flat[63*16 +: 16] = 16'hFFFF;
        in_valid = 1'b1;
        step();
        for (int p = 0; p < 64; p++) begin
            exp = (p == 2) ? -21 : (p == 63) ? -2147450880 : 0;
            checks++;
            if (lane(p) !== exp) begin
                errors++;
                $display("FAIL sign_pos%0d got %0d want %0d", p, lane(p), exp);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_hold_reset();
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            zz_in_flat[k*16 +: 16] = 16'd4;
            quant_flat[k*16 +: 16] = 16'd9;
        end
        in_valid = 1'b1;
        step();
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 64; k++) zz_in_flat[k*16 +: 16] = 16'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_valid cyc%0d got %b want 0", i, out_valid);
            end
            for (int p = 0; p < 64; p++) begin
                checks++;
                if (lane(p) !== 36) begin
                    errors++;
                    $display("FAIL hold_pos%0d cyc%0d got %0d want 36", p, i, lane(p));
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid got %b want 0", out_valid);
        end
        checks++;
        if (dct_out_flat !== '0) begin
            errors++;
            $display("FAIL midreset_data got nonzero want 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            zz_in_flat[k*16 +: 16] = 16'(k);
            quant_flat[k*16 +: 16] = 16'd2;
        end
        in_valid = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_a_valid got %b want 1", out_valid);
        end
        for (int p = 0; p < 64; p++) begin
            checks++;
            if (lane(p) !== 2*ZZ_TAB[p]) begin
                errors++;
                $display("FAIL b2b_a_pos%0d got %0d want %0d", p, lane(p), 2*ZZ_TAB[p]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            zz_in_flat[k*16 +: 16] = 16'(-k);
            quant_flat[k*16 +: 16] = 16'd3;
        end
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_b_valid got %b want 1", out_valid);
        end
        for (int p = 0; p < 64; p++) begin
            checks++;
            if (lane(p) !== -3*ZZ_TAB[p]) begin
                errors++;
                $display("FAIL b2b_b_pos%0d got %0d want %0d", p, lane(p), -3*ZZ_TAB[p]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end_valid got %b want 0", out_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        zz_in_flat = '0;
        quant_flat = '0;
        test_reset();
        test_zigzag();
        test_multiply();
        test_sparse();
        test_sign();
        test_hold_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
